// File: rtl/q_edge_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : q_edge_monitor
// Brief   : Stability filter on a sampled flip-flop output with rise/fall
//           pulses, saturating event counters and a rise-count threshold hit.
// Revision: 1.0 - initial release
// ============================================================================
module q_edge_monitor #(
    parameter int COUNT_W    = 8,
    parameter int FILTER_LEN = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               q_in,
    input  logic               enable,
    input  logic               clear,
    input  logic [COUNT_W-1:0] threshold,
    output logic               level,
    output logic               rise_pulse,
    output logic               fall_pulse,
    output logic [COUNT_W-1:0] rise_count,
    output logic [COUNT_W-1:0] fall_count,
    output logic               hit,
    output logic               overflow
);

    localparam int                  c_stab_w    = $clog2(FILTER_LEN) + 1;
    localparam logic [c_stab_w-1:0] c_stab_last = c_stab_w'(FILTER_LEN - 1);
    localparam logic [c_stab_w-1:0] c_stab_one  = c_stab_w'(1);
    localparam logic [COUNT_W-1:0]  c_count_max = '1;
    localparam logic [COUNT_W-1:0]  c_count_one = COUNT_W'(1);

    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                r_state;
    logic [c_stab_w-1:0]   r_stab_cnt;
    logic                  r_q_s;
    logic                  r_level;
    logic                  r_rise_pulse;
    logic                  r_fall_pulse;
    logic [COUNT_W-1:0]    r_rise_count;
    logic [COUNT_W-1:0]    r_fall_count;
    logic                  r_hit;
    logic                  r_overflow;

    logic                  w_differ;
    logic                  w_accept;
    logic                  w_rise_acc;
    logic                  w_fall_acc;
    logic [COUNT_W-1:0]    w_rise_next;
    logic [COUNT_W-1:0]    w_fall_next;

    assign w_differ = (r_q_s != r_level);

    // The first differing edge counts as one stable cycle, so a single-cycle
    // filter accepts straight from STABLE.
    assign w_accept = w_differ &&
                      (((r_state == ST_STABLE) && (FILTER_LEN == 1)) ||
                       ((r_state == ST_PENDING) && (r_stab_cnt == c_stab_last)));

    assign w_rise_acc  = w_accept & ~r_level;
    assign w_fall_acc  = w_accept &  r_level;
    assign w_rise_next = r_rise_count + c_count_one;
    assign w_fall_next = r_fall_count + c_count_one;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_STABLE;
            r_stab_cnt   <= '0;
            r_q_s        <= 1'b0;
            r_level      <= 1'b0;
            r_rise_pulse <= 1'b0;
            r_fall_pulse <= 1'b0;
            r_rise_count <= '0;
            r_fall_count <= '0;
            r_hit        <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_q_s        <= q_in;
            r_rise_pulse <= w_rise_acc;
            r_fall_pulse <= w_fall_acc;

            case (r_state)
                ST_STABLE: begin
                    if (w_accept) begin
                        r_level    <= r_q_s;
                        r_stab_cnt <= '0;
                    end else if (w_differ) begin
                        r_state    <= ST_PENDING;
                        r_stab_cnt <= c_stab_one;
                    end
                end
                ST_PENDING: begin
                    if (!w_differ || w_accept) begin
                        r_state    <= ST_STABLE;
                        r_stab_cnt <= '0;
                        if (w_accept) begin
                            r_level <= r_q_s;
                        end
                    end else begin
                        r_stab_cnt <= r_stab_cnt + c_stab_one;
                    end
                end
                default: begin
                    r_state    <= ST_STABLE;
                    r_stab_cnt <= '0;
                end
            endcase

            r_hit <= 1'b0;
            if (clear) begin
                r_rise_count <= '0;
                r_fall_count <= '0;
                r_overflow   <= 1'b0;
            end else begin
                if (w_rise_acc && enable) begin
                    if (r_rise_count == c_count_max) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_rise_count <= w_rise_next;
                        if ((w_rise_next == threshold) && (threshold != '0)) begin
                            r_hit <= 1'b1;
                        end
                    end
                end
                if (w_fall_acc && enable) begin
                    if (r_fall_count == c_count_max) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_fall_count <= w_fall_next;
                    end
                end
            end
        end
    end

    assign level      = r_level;
    assign rise_pulse = r_rise_pulse;
    assign fall_pulse = r_fall_pulse;
    assign rise_count = r_rise_count;
    assign fall_count = r_fall_count;
    assign hit        = r_hit;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_q_edge_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_q_edge_monitor
// Brief   : Self-checking bench for q_edge_monitor against a sample-history model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_q_edge_monitor;

    localparam int COUNT_W    = 8;
    localparam int FILTER_LEN = 2;
    localparam int c_max      = (1 << COUNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               q_in;
    logic               enable;
    logic               clear;
    logic [COUNT_W-1:0] threshold;
    logic               level;
    logic               rise_pulse;
    logic               fall_pulse;
    logic [COUNT_W-1:0] rise_count;
    logic [COUNT_W-1:0] fall_count;
    logic               hit;
    logic               overflow;

    q_edge_monitor #(
        .COUNT_W    (COUNT_W),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .q_in       (q_in),
        .enable     (enable),
        .clear      (clear),
        .threshold  (threshold),
        .level      (level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .rise_count (rise_count),
        .fall_count (fall_count),
        .hit        (hit),
        .overflow   (overflow)
    );

    always #10 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int obs_rise    = 0;
    int obs_fall    = 0;
    int obs_hit     = 0;

    // Model: a transition is accepted once the last FILTER_LEN filter-visible
    // samples all disagree with the accepted level.
    bit m_qs, m_level, m_rp, m_fp, m_hit, m_ovf;
    int m_rc, m_fc;
    bit hist[$];

    task automatic model_step();
        bit acc;
        if (reset) begin
            m_qs = 0; m_level = 0; m_rp = 0; m_fp = 0; m_hit = 0; m_ovf = 0;
            m_rc = 0; m_fc = 0;
            hist.delete();
        end else begin
            hist.push_back(m_qs);
            if (hist.size() > FILTER_LEN) void'(hist.pop_front());
            acc = (hist.size() == FILTER_LEN);
            foreach (hist[i]) if (hist[i] == m_level) acc = 0;
            m_rp  = acc && !m_level;
            m_fp  = acc && m_level;
            m_hit = 0;
            if (acc && enable) begin
                if (!m_level) begin
                    if (m_rc == c_max) m_ovf = 1;
                    else begin
                        m_rc++;
                        if (m_rc == int'(threshold) && threshold != 0) m_hit = 1;
                    end
                end else begin
                    if (m_fc == c_max) m_ovf = 1;
                    else m_fc++;
                end
            end
            if (clear) begin
                m_rc = 0; m_fc = 0; m_ovf = 0; m_hit = 0;
            end
            if (acc) m_level = !m_level;
            m_qs = q_in;
        end
    endtask

    initial begin
        logic [20:0] act, exp;
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            act = {level, rise_pulse, fall_pulse, rise_count, fall_count, hit, overflow};
            exp = {m_level, m_rp, m_fp, COUNT_W'(m_rc), COUNT_W'(m_fc), m_hit, m_ovf};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL cycle t=%0t dut=%h model=%h", $time, act, exp);
            end
            if (rise_pulse === 1'b1) obs_rise++;
            if (fall_pulse === 1'b1) obs_fall++;
            if (hit === 1'b1)        obs_hit++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic do_rises(input int n, input int hi, input int lo);
        repeat (n) begin
            q_in = 1'b1;
            tick(hi);
            q_in = 1'b0;
            tick(lo);
        end
    endtask

    initial begin
        int r0, f0, h0;
        reset = 1'b1; q_in = 1'b1; enable = 1'b1; clear = 1'b0; threshold = '0;
        tick(2);
        chk("reset_outputs",
            {level, rise_pulse, fall_pulse, rise_count, fall_count, hit, overflow}, 0);
        reset = 1'b0;
        tick(1); chk("rel_c1_rise", rise_pulse, 0);
        tick(1); chk("rel_c2_rise", rise_pulse, 0); chk("rel_c2_level", level, 0);
        tick(1); chk("rel_c3_rise", rise_pulse, 1); chk("rel_c3_level", level, 1);
        q_in = 1'b0;
        tick(6);
        pulse_clear();

        // Toggle every 50 ns, offset so edges of q_in never meet clock edges.
        r0 = obs_rise; f0 = obs_fall;
        #4;
        repeat (8) begin
            q_in = ~q_in;
            #50;
        end
        tick(5);
        chk("toggle_rise_count", rise_count, 4);
        chk("toggle_fall_count", fall_count, 4);
        chk("toggle_rise_pulses", obs_rise - r0, 4);
        chk("toggle_fall_pulses", obs_fall - f0, 4);

        pulse_clear();
        r0 = obs_rise; f0 = obs_fall;
        q_in = 1'b1; tick(1); q_in = 1'b0; tick(5);
        chk("glitch_level", level, 0);
        chk("glitch_count", rise_count, 0);
        chk("glitch_pulses", obs_rise - r0, 0);
        q_in = 1'b1; tick(2); q_in = 1'b0; tick(6);
        chk("min_pulse_rise", obs_rise - r0, 1);
        chk("min_pulse_fall", obs_fall - f0, 1);

        pulse_clear();
        threshold = 8'd3;
        h0 = obs_hit;
        do_rises(5, 3, 3);
        chk("thr3_hits", obs_hit - h0, 1);
        chk("thr3_count", rise_count, 5);
        threshold = '0;
        pulse_clear();
        h0 = obs_hit;
        do_rises(5, 3, 3);
        chk("thr0_hits", obs_hit - h0, 0);

        pulse_clear();
        do_rises(258, 2, 2);
        tick(3);
        chk("sat_rise_count", rise_count, c_max);
        chk("sat_fall_count", fall_count, c_max);
        chk("sat_overflow", overflow, 1);
        pulse_clear();
        chk("clr_count", rise_count, 0);
        chk("clr_overflow", overflow, 0);

        do_rises(2, 3, 3);
        q_in = 1'b1;
        tick(2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clr_accept_pulse", rise_pulse, 1);
        chk("clr_accept_count", rise_count, 0);
        q_in = 1'b0;
        tick(6);

        enable = 1'b0;
        r0 = obs_rise;
        do_rises(3, 3, 3);
        chk("disabled_pulses", obs_rise - r0, 3);
        chk("disabled_count", rise_count, 0);
        enable = 1'b1;

        q_in = 1'b1;
        tick(2);
        reset = 1'b1; q_in = 1'b0;
        tick(2);
        reset = 1'b0;
        r0 = obs_rise;
        tick(6);
        chk("reset_pending_pulses", obs_rise - r0, 0);
        chk("reset_pending_level", level, 0);

        repeat (3000) begin
            if ($urandom_range(0, 2) == 0) q_in = ~q_in;
            enable = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 49) == 0);
            reset  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) threshold = COUNT_W'($urandom_range(0, 6));
            tick(1);
        end
        reset = 1'b0; clear = 1'b0;
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/q_edge_monitor.md
# q_edge_monitor

Downstream consumer of the `flipFlop` storage stage. It samples the flip-flop's `q` output and filters it for stability. It reports each accepted rising and falling transition as a one-cycle pulse and keeps saturating counts of both. A single-cycle `hit` fires when the rise count reaches a programmable threshold, which lets the bench and higher-level logic check stored-bit toggling without open-coded waveform inspection.

## Interface
- `COUNT_W`, 8: width of both event counters and of `threshold`.
- `FILTER_LEN`, 2: consecutive cycles the sampled input must differ from the accepted level before a transition is accepted. Legal range is 1..255.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the rising edge of `clock` where it is 1.
- `q_in`  in  1  driven from `flipFlop` `q`.
- `enable`  in  1  count enable; pulses are generated regardless.
- `clear`  in  1  synchronous clear of counters, `hit` and `overflow`.
- `threshold`  in  `COUNT_W`  rise-count match value; 0 disables `hit`.
- `level`  out  1  filtered, accepted value of `q_in`.
- `rise_pulse`  out  1  one cycle high per accepted 0→1 transition.
- `fall_pulse`  out  1  one cycle high per accepted 1→0 transition.
- `rise_count`  out  `COUNT_W`  saturating count of accepted rises.
- `fall_count`  out  `COUNT_W`  saturating count of accepted falls.
- `hit`  out  1  one cycle high when `rise_count` becomes equal to `threshold`.
- `overflow`  out  1  sticky; set when either counter is incremented while at all-ones.

## Operation
- **Input sampling**
  - `q_in` is registered once into `q_s`, so no combinational path exists from `q_in`.
- **Filter FSM**, with a stability counter `stab_cnt` of width ceil(log2(FILTER_LEN))+1:
  - STABLE: `q_s == level` and `stab_cnt` = 0. On `q_s != level`, the FSM goes to PENDING.
    - If `FILTER_LEN` = 1, the transition is accepted on that same edge instead.
  - PENDING: on each edge with `q_s != level`:
    - If `stab_cnt == FILTER_LEN-1`, accept the transition: `level <= q_s`, `stab_cnt <= 0`, next state STABLE.
    - Otherwise, `stab_cnt <= stab_cnt+1`.
  - PENDING, glitch case: any edge with `q_s == level` sets `stab_cnt <= 0`, next state STABLE, and generates no pulse.
- **Acceptance**
  - An accepted 0→1 registers `rise_pulse` = 1 for exactly the following cycle.
  - An accepted 1→0 registers `fall_pulse` = 1 for exactly the following cycle.
  - `rise_pulse` and `fall_pulse` are never high together.
- **Counting** (only when `enable` = 1 on the accept edge)
  - Matching counter increments by 1.
  - At all-ones the counter holds and `overflow` <= 1.
- **hit**
  - Registered high for one cycle when a rise increment produces `rise_count == threshold` and `threshold != 0`.
  - Saturation holding at a value equal to `threshold` does not re-fire `hit`.
  - A change of `threshold` never fires `hit` on its own.
- **clear**
  - Zeroes `rise_count`, `fall_count`, `overflow` and `hit`.
  - Leaves `q_s`, `level`, `stab_cnt` and the pulses untouched.
  - Clear together with an accept edge: clear wins, the count is 0 and `hit` stays 0, but the pulse is still generated.
- **reset**
  - Takes priority over everything.
  - Zeroes `q_s`, `level`, `stab_cnt`, all counters and all outputs; FSM goes to STABLE.
  - Mid-PENDING reset discards the pending transition.

## Timing
- Reset values: `level`=0, `rise_pulse`=0, `fall_pulse`=0, `rise_count`=0, `fall_count`=0, `hit`=0, `overflow`=0.
- Latency: `q_in` is sampled at edge k and held stable. `level` changes at edge k+`FILTER_LEN`, and the pulse and count update are visible in the cycle after that same edge.
- `hit` asserts in the same cycle as the `rise_count` value that equals `threshold`.
- Minimum accepted pulse width on `q_in` is `FILTER_LEN` cycles; shorter pulses are ignored.
- Back-to-back transitions:
  - An opposite transition can be accepted `FILTER_LEN` edges after the previous accept.
  - With `FILTER_LEN`=1, `q_in` toggling every cycle produces alternating pulses every cycle.

## Test plan
- **Reset.** Assert `reset` for 2 cycles with `q_in`=1 → all outputs 0. Release → `level`=1 and `rise_pulse` high exactly at the FILTER_LEN+1 cycle point (`FILTER_LEN`=2: 3rd cycle after release).
- **Toggle sequence.** Clock period 20 ns, `q_in` toggled every 50 ns for 8 toggles, `enable`=1, `FILTER_LEN`=2 → `rise_count`=4, `fall_count`=4, 8 single-cycle pulses alternating rise/fall.
- **Glitch filtering.** 1-cycle high glitch on `q_in` with `FILTER_LEN`=2 → no pulse, `level` stays 0, counts unchanged. A 2-cycle high pulse → one `rise_pulse` and one `fall_pulse`.
- **Threshold match.** `threshold`=3, 5 rises → `hit` high only in the cycle `rise_count` becomes 3. `threshold`=0 → `hit` never asserts.
- **Saturation.** `COUNT_W`=2, 5 rises → `rise_count` sticks at 3, `overflow`=1 from the 4th rise onward. `clear` → counts 0, `overflow` 0.
- **Priorities.** `clear` on the accept edge → `rise_pulse` high, `rise_count`=0. `enable`=0 during 3 rises → 3 pulses, count unchanged. `reset` while PENDING → no pulse follows.
